player_ctrl: RTL and testbench

PLAYER_CTRL -- requirements
Module: player_ctrl

---
 rtl/player_ctrl.sv | 152 +++++++++++++++
 tb/tb_player_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// Player movement/jump/health controller for one on-screen player sprite.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for the first round to start, player frozen
// GROUND | standing on ground: walk, squat, shield, may start a jump
// JUMP   | airborne: jump counter jc drives the vertical profile
// DEAD   | hp exhausted, outputs frozen until the next start pulse
module player_ctrl #(
  parameter int          STEP_X   = 6,
  parameter int          V        = 8,
  parameter int          MAX_J    = 32,
  parameter int          X_MIN    = 0,
  parameter int          X_MAX    = 480,
  parameter int          X_INIT   = 120,
  parameter int          HP_WIDTH = 3,
  parameter int          HP_INIT  = 5,
  parameter logic [3:0]  BASE_ID  = 4'd1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_frame_tick,
  input  logic                i_left,
  input  logic                i_right,
  input  logic                i_jump,
  input  logic                i_squat,
  input  logic                i_shield,
  input  logic                i_hit,
  output logic [10:0]         o_x,
  output logic [7:0]          o_y_off,
  output logic [3:0]          o_obj_id,
  output logic [HP_WIDTH-1:0] o_hp,
  output logic                o_dead
);

  localparam int JCW  = $clog2(MAX_J + 1);
  localparam int HALF = MAX_J / 2;

  typedef enum logic [1:0] {IDLE, GROUND, JUMP, DEAD} state_t;

  state_t                state_q, state_d;
  logic [10:0]           x_q, x_d;
  logic [7:0]            y_off_q, y_off_d;
  logic [JCW-1:0]        jc_q, jc_d;
  logic [3:0]            obj_id_q, obj_id_d;
  logic [HP_WIDTH-1:0]   hp_q, hp_d;
  logic                  dead_q, dead_d;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      x_q      <= 11'(X_INIT);
      y_off_q  <= 8'd0;
      jc_q     <= '0;
      obj_id_q <= BASE_ID;
      hp_q     <= HP_WIDTH'(HP_INIT);
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_off_q  <= y_off_d;
      jc_q     <= jc_d;
      obj_id_q <= obj_id_d;
      hp_q     <= hp_d;
      dead_q   <= dead_d;
    end
  end

  // Next state: start wins; otherwise frame-tick motion and per-cycle hit handling.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_off_d  = y_off_q;
    jc_d     = jc_q;
    obj_id_d = obj_id_q;
    hp_d     = hp_q;
    dead_d   = dead_q;

    if (i_start) begin
      state_d  = GROUND;
      x_d      = 11'(X_INIT);
      y_off_d  = 8'd0;
      jc_d     = '0;
      obj_id_d = BASE_ID;
      hp_d     = HP_WIDTH'(HP_INIT);
      dead_d   = 1'b0;
    end else if (state_q == GROUND || state_q == JUMP) begin
      if (i_frame_tick) begin
        // Horizontal move; compares are done before subtracting so x never underflows.
        if (i_left && !i_right) begin
          if (x_q >= 11'(X_MIN + STEP_X))
            x_d = x_q - 11'(STEP_X);
          else
            x_d = 11'(X_MIN);
        end else if (i_right && !i_left) begin
          if (({1'b0, x_q} + 12'(STEP_X)) >= 12'(X_MAX))
            x_d = 11'(X_MAX);
          else
            x_d = x_q + 11'(STEP_X);
        end

        if (state_q == GROUND) begin
          if (i_shield)
            obj_id_d = BASE_ID + 4'd1;
          else if (i_squat)
            obj_id_d = BASE_ID + 4'd2;
          else
            obj_id_d = BASE_ID;
          if (i_jump && !i_squat) begin
            state_d  = JUMP;
            jc_d     = '0;
            obj_id_d = BASE_ID;
          end
        end else begin
          obj_id_d = BASE_ID;
          // Rising half slows by one pixel every two frames; falling half mirrors it.
          if (jc_q < JCW'(HALF))
            y_off_d = y_off_q + 8'(V) - 8'(jc_q >> 1);
          else
            y_off_d = y_off_q - 8'((jc_q - JCW'(HALF)) >> 1) - 8'd1;
          if (jc_q == JCW'(MAX_J - 1)) begin
            y_off_d = 8'd0;
            jc_d    = '0;
            state_d = GROUND;
          end else begin
            jc_d = jc_q + JCW'(1);
          end
        end
      end

      // Hits are checked against the sprite currently shown, so the shield
      // only protects once it is actually displayed.
      if (i_hit && (obj_id_q != BASE_ID + 4'd1) && (hp_q != '0)) begin
        hp_d = hp_q - HP_WIDTH'(1);
        if (hp_q == HP_WIDTH'(1)) begin
          state_d  = DEAD;
          dead_d   = 1'b1;
          obj_id_d = BASE_ID;
        end
      end
    end
  end

  assign o_x      = x_q;
  assign o_y_off  = y_off_q;
  assign o_obj_id = obj_id_q;
  assign o_hp     = hp_q;
  assign o_dead   = dead_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: the driver queues the expected output
// snapshot for the cycle it stimulates, the monitor compares when it is due.
module tb_player_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, tick, left, right, jump, squat, shield, hit;
  logic [10:0] o_x;
  logic [7:0]  o_y_off;
  logic [3:0]  o_obj_id;
  logic [2:0]  o_hp;
  logic        o_dead;

  player_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_frame_tick (tick),
    .i_left       (left),
    .i_right      (right),
    .i_jump       (jump),
    .i_squat      (squat),
    .i_shield     (shield),
    .i_hit        (hit),
    .o_x          (o_x),
    .o_y_off      (o_y_off),
    .o_obj_id     (o_obj_id),
    .o_hp         (o_hp),
    .o_dead       (o_dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    due;
    int    x;
    int    y;
    int    obj;
    int    hp;
    int    dead;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are stable at the falling edge; compare every entry due now.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (e.due < cyc) begin
          errors++;
          $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.nm, e.due, cyc);
        end else if (int'(o_x) != e.x || int'(o_y_off) != e.y || int'(o_obj_id) != e.obj ||
                     int'(o_hp) != e.hp || int'(o_dead) != e.dead) begin
          errors++;
          $display("FAIL %s @%0d: got x=%0d y=%0d obj=%0d hp=%0d dead=%0d, want x=%0d y=%0d obj=%0d hp=%0d dead=%0d",
                   e.nm, cyc, o_x, o_y_off, o_obj_id, o_hp, o_dead, e.x, e.y, e.obj, e.hp, e.dead);
        end
      end
    end
  end

  task automatic drv(input logic tk, l, r, j, sq, sh, ht, st, input logic rs = 1'b1);
    @(negedge clk);
    rst_n  = rs;
    tick   = tk;
    left   = l;
    right  = r;
    jump   = j;
    squat  = sq;
    shield = sh;
    hit    = ht;
    start  = st;
  endtask

  // Expected outputs after the upcoming rising edge.
  task automatic chk(input string nm, input int x, y, obj, hp, dead);
    exp_t e;
    e.nm = nm; e.due = cyc + 1;
    e.x = x; e.y = y; e.obj = obj; e.hp = hp; e.dead = dead;
    exp_q.push_back(e);
  endtask

  int ylist[32] = '{8, 16, 23, 30, 36, 42, 47, 52, 56, 60, 63, 66, 68, 70, 71, 72,
                    71, 70, 68, 66, 63, 60, 56, 52, 47, 42, 36, 30, 23, 16, 8, 0};

  initial begin
    int ex;
    rst_n = 1'b0; start = 0; tick = 0; left = 0; right = 0;
    jump = 0; squat = 0; shield = 0; hit = 0;

    // Reset values, then ticks in IDLE do nothing
    drv(0,0,0,0,0,0,0,0, 1'b0); chk("reset", 120, 0, 1, 5, 0);
    drv(1,0,1,0,0,0,1,0, 1'b0); chk("reset_hold", 120, 0, 1, 5, 0);
    drv(1,0,1,0,0,0,0,0);       chk("idle_tick", 120, 0, 1, 5, 0);
    drv(0,0,0,0,0,0,1,0);       chk("idle_hit", 120, 0, 1, 5, 0);

    // Walk right to saturation; non-tick cycles must not move
    drv(0,0,0,0,0,0,0,1); chk("start1", 120, 0, 1, 5, 0);
    for (int k = 1; k <= 100; k++) begin
      ex = (120 + 6 * k > 480) ? 480 : 120 + 6 * k;
      drv(1,0,1,0,0,0,0,0); chk("right", ex, 0, 1, 5, 0);
      if (k <= 3) begin
        drv(0,0,1,0,0,0,0,0); chk("right_notick", ex, 0, 1, 5, 0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drv(1,1,1,0,0,0,0,0); chk("both", 480, 0, 1, 5, 0);
    end

    // Walk left to the exact minimum, no wrap
    drv(0,0,0,0,0,0,0,1); chk("start2", 120, 0, 1, 5, 0);
    for (int k = 1; k <= 25; k++) begin
      ex = (120 - 6 * k < 0) ? 0 : 120 - 6 * k;
      drv(1,1,0,0,0,0,0,0); chk("left", ex, 0, 1, 5, 0);
    end

    // Full jump; squat at jump tick 5 and re-jump at tick 10 have no effect
    drv(0,0,0,0,0,0,0,1); chk("start3", 120, 0, 1, 5, 0);
    drv(1,0,0,1,0,0,0,0); chk("jump_enter", 120, 0, 1, 5, 0);
    for (int k = 0; k < 32; k++) begin
      drv(1,0,0,(k == 10),(k == 5),0,0,0); chk("jump_y", 120, ylist[k], 1, 5, 0);
    end
    drv(1,0,0,0,1,0,0,0); chk("ground_squat", 120, 0, 3, 5, 0);
    drv(1,0,0,0,0,0,0,0); chk("ground_plain", 120, 0, 1, 5, 0);

    // Shield blocks hits only while shown; then drain hp to zero
    drv(0,0,0,0,0,0,0,1); chk("start4", 120, 0, 1, 5, 0);
    drv(1,0,0,0,0,1,0,0); chk("shield_on", 120, 0, 2, 5, 0);
    for (int k = 0; k < 3; k++) begin
      drv(0,0,0,0,0,1,1,0); chk("shield_hit", 120, 0, 2, 5, 0);
    end
    drv(0,0,0,0,0,0,1,0); chk("shield_release_notick", 120, 0, 2, 5, 0);
    drv(1,0,0,0,0,0,0,0); chk("shield_off", 120, 0, 1, 5, 0);
    for (int k = 1; k <= 5; k++) begin
      drv(0,0,0,0,0,0,1,0); chk("hit", 120, 0, 1, 5 - k, (k == 5));
    end
    drv(0,0,0,0,0,0,1,0); chk("hit_dead", 120, 0, 1, 0, 1);
    drv(1,0,1,1,0,0,0,0); chk("dead_frozen", 120, 0, 1, 0, 1);

    // Start beats hit; hit and tick together mid-jump
    drv(0,0,0,0,0,0,1,1); chk("start_hit", 120, 0, 1, 5, 0);
    drv(1,0,0,1,0,0,0,0); chk("jump2_enter", 120, 0, 1, 5, 0);
    for (int k = 0; k < 3; k++) begin
      drv(1,0,0,0,0,0,0,0); chk("jump2_y", 120, ylist[k], 1, 5, 0);
    end
    drv(1,0,0,0,0,0,1,0); chk("hit_tick", 120, 30, 1, 4, 0);
    drv(1,0,1,0,0,0,1,1); chk("start_hit_tick", 120, 0, 1, 5, 0);

    // Reset at jc=7 abandons the jump; no motion until start; jc restarts at 0
    drv(1,0,1,1,0,0,0,0); chk("jump3_enter", 126, 0, 1, 5, 0);
    for (int k = 0; k < 7; k++) begin
      drv(1,0,1,0,0,0,0,0); chk("jump3_xy", 132 + 6 * k, ylist[k], 1, 5, 0);
    end
    drv(1,0,1,0,0,0,0,0, 1'b0); chk("mid_jump_reset", 120, 0, 1, 5, 0);
    for (int k = 0; k < 3; k++) begin
      drv(1,0,1,1,0,0,0,0); chk("post_reset_idle", 120, 0, 1, 5, 0);
    end
    drv(0,0,0,0,0,0,0,1); chk("start5", 120, 0, 1, 5, 0);
    drv(1,0,0,1,0,0,0,0); chk("jump4_enter", 120, 0, 1, 5, 0);
    drv(1,0,0,0,0,0,0,0); chk("jump4_first", 120, 8, 1, 5, 0);

    drv(0,0,0,0,0,0,0,0);
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d checks still pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
